// File: rtl/fir_pkg.sv
// Shared types and helpers for the FIR filter / inverse pair.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DIV,
    OUT
  } fsm_t;

  function automatic int fir_width_y(
    input int wx,
    input int wb,
    input int n
  );
    return wx + wb + n + 1;
  endfunction

  function automatic int fir_sat(
    input int v,
    input int w
  );
    int hi;
    int lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/fir_inverse_div.sv
// Serial restoring divider: signed dividend by unsigned divisor,
// one quotient bit per cycle, quotient truncated toward zero.
module serial_div_u #(
  parameter int WIDTH_ACC = 14,
  parameter int WIDTH_B   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic signed [WIDTH_ACC-1:0] dividend,
  input  logic        [WIDTH_B-1:0]   divisor,
  output logic                        done,
  output logic signed [WIDTH_ACC:0]   quotient,
  output logic                        remainder_nz
);

  localparam int CW = $clog2(WIDTH_ACC + 1);

  logic [WIDTH_ACC-1:0] q;
  logic [WIDTH_B-1:0]   r;
  logic [WIDTH_B-1:0]   d;
  logic                 neg;
  logic                 busy;
  logic [CW-1:0]        cnt;
  logic [WIDTH_B:0]     t;

  assign t = {r, q[WIDTH_ACC-1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= '0;
      r    <= '0;
      d    <= '0;
      neg  <= 1'b0;
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      q    <= dividend[WIDTH_ACC-1] ? $unsigned(-dividend)
                                    : $unsigned(dividend);
      r    <= '0;
      d    <= divisor;
      neg  <= dividend[WIDTH_ACC-1];
      busy <= 1'b1;
      cnt  <= '0;
    end else if (busy && cnt != CW'(WIDTH_ACC)) begin
      if (t >= {1'b0, d}) begin
        r <= WIDTH_B'(t - {1'b0, d});
        q <= {q[WIDTH_ACC-2:0], 1'b1};
      end else begin
        r <= t[WIDTH_B-1:0];
        q <= {q[WIDTH_ACC-2:0], 1'b0};
      end
      cnt <= cnt + 1'b1;
    end
  end

  assign done         = busy && (cnt == CW'(WIDTH_ACC));
  assign quotient     = neg ? -$signed({1'b0, q}) : $signed({1'b0, q});
  assign remainder_nz = |r;

endmodule

// File: rtl/fir_inverse.sv
// Inverse FIR: recovers x from y by serial MAC then serial divide.
// FIR_INV_DIV_SKIP_EN bypasses the divider when B[0] == 1.
module fir_inverse
  import fir_pkg::*;
#(
  parameter int N       = 3,
  parameter int WIDTH_X = 4,
  parameter int WIDTH_B = 4,
  parameter int WIDTH_Y = fir_width_y(WIDTH_X, WIDTH_B, N),
  parameter logic [WIDTH_B-1:0] B [N+1] = '{4'd1, 4'd2, 4'd3, 4'd4}
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [WIDTH_Y-1:0] y,
  input  logic                      y_valid,
  output logic                      y_ready,
  output logic signed [WIDTH_X-1:0] x,
  output logic                      x_valid,
  input  logic                      x_ready,
  output logic                      err
);

  localparam int WACC = WIDTH_Y + 2;
  localparam int WQ   = WACC + 1;
  localparam int KW   = $clog2(N + 1);

`ifdef FIR_INV_DIV_SKIP_EN
  localparam bit SKIP = (B[0] == WIDTH_B'(1));
`else
  localparam bit SKIP = 1'b0;
`endif

  if (B[0] == '0) begin : g_b0_zero
    $error("fir_inverse: B[0] must be nonzero");
  end

  fsm_t                      state;
  logic [KW-1:0]             k;
  logic signed [WACC-1:0]    acc;
  logic signed [WIDTH_X-1:0] hist [1:N];

  logic signed [WACC-1:0] hx;
  logic signed [WACC-1:0] bx;
  logic signed [WACC-1:0] acc_nxt;
  logic                   div_start;
  logic                   div_done;
  logic signed [WQ-1:0]   div_q;
  logic                   div_rnz;
  logic signed [WQ-1:0]   qv;
  logic                   fin;
  logic                   rnz;
  int                     sat_v;
  logic                   satd;

  always_comb begin
    hx      = WACC'(hist[k]);
    bx      = $signed(WACC'(B[k]));
    acc_nxt = acc - hx * bx;
  end

  // The divider latches the final accumulator on the last MAC edge.
  assign div_start = (state == MAC) && (k == KW'(N));

  serial_div_u #(
    .WIDTH_ACC(WACC),
    .WIDTH_B  (WIDTH_B)
  ) u_div (
    .clk         (clk),
    .rst         (rst),
    .start       (div_start),
    .dividend    (acc_nxt),
    .divisor     (B[0]),
    .done        (div_done),
    .quotient    (div_q),
    .remainder_nz(div_rnz)
  );

  always_comb begin
    qv    = SKIP ? WQ'(acc) : div_q;
    fin   = SKIP ? 1'b1 : div_done;
    rnz   = SKIP ? 1'b0 : div_rnz;
    sat_v = fir_sat(int'(qv), WIDTH_X);
    satd  = (sat_v != int'(qv));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      y_ready <= 1'b1;
      x_valid <= 1'b0;
      x       <= '0;
      err     <= 1'b0;
      acc     <= '0;
      k       <= '0;
      for (int i = 1; i <= N; i++) hist[i] <= '0;
    end else begin
      unique case (state)
        IDLE: if (y_valid) begin
          acc     <= WACC'(y);
          k       <= KW'(1);
          y_ready <= 1'b0;
          state   <= MAC;
        end
        MAC: begin
          acc <= acc_nxt;
          if (k == KW'(N)) state <= DIV;
          else k <= k + 1'b1;
        end
        DIV: if (fin) begin
          x       <= WIDTH_X'(sat_v);
          err     <= rnz | satd;
          hist[1] <= WIDTH_X'(sat_v);
          for (int i = 2; i <= N; i++) hist[i] <= hist[i-1];
          x_valid <= 1'b1;
          state   <= OUT;
        end
        OUT: if (x_ready) begin
          x_valid <= 1'b0;
          y_ready <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_inverse.sv
// Bench for fir_inverse: two instances (default B and B={2,1,1,1})
// checked against an arithmetic deconvolution model.
module tb_fir_inverse;

`ifdef FIR_INV_DIV_SKIP_EN
  localparam bit SKIP0 = 1'b1;
`else
  localparam bit SKIP0 = 1'b0;
`endif

  logic              clk;
  logic              rst     [2];
  logic signed [11:0] y      [2];
  logic              y_valid [2];
  logic              y_ready [2];
  logic signed [3:0] x       [2];
  logic              x_valid [2];
  logic              x_ready [2];
  logic              err     [2];

  int checks = 0;
  int errors = 0;

  int mb [2][4] = '{'{1, 2, 3, 4}, '{2, 1, 1, 1}};
  int mh [2][4];

  fir_inverse dut0 (
    .clk(clk), .rst(rst[0]), .y(y[0]), .y_valid(y_valid[0]),
    .y_ready(y_ready[0]), .x(x[0]), .x_valid(x_valid[0]),
    .x_ready(x_ready[0]), .err(err[0])
  );

  fir_inverse #(
    .B('{4'd2, 4'd1, 4'd1, 4'd1})
  ) dut1 (
    .clk(clk), .rst(rst[1]), .y(y[1]), .y_valid(y_valid[1]),
    .y_ready(y_ready[1]), .x(x[1]), .x_valid(x_valid[1]),
    .x_ready(x_ready[1]), .err(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model(input int u, input int yv,
                       output int ex, output int ee);
    int a;
    int q;
    int r;
    a = yv;
    for (int j = 1; j <= 3; j++) a -= mb[u][j] * mh[u][j];
    q  = a / mb[u][0];
    r  = a % mb[u][0];
    ex = (q > 7) ? 7 : (q < -8) ? -8 : q;
    ee = (r != 0 || ex != q) ? 1 : 0;
    mh[u][3] = mh[u][2];
    mh[u][2] = mh[u][1];
    mh[u][1] = ex;
  endtask

  task automatic send(input int u, input int yv, input int hold);
    int ex;
    int ee;
    int lat;
    int cnt;
    int exp_lat;
    cnt = 0;
    while (!y_ready[u] && cnt < 100) begin
      @(posedge clk); #1; cnt++;
    end
    chk("y_ready_before_send", int'(y_ready[u]), 1);
    y[u]       = 12'(yv);
    y_valid[u] = 1'b1;
    @(posedge clk); #1;
    y_valid[u] = 1'b0;
    model(u, yv, ex, ee);
    exp_lat = (u == 0 && SKIP0) ? 4 : 18;
    lat = 0;
    while (!x_valid[u] && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    chk("latency", lat, exp_lat);
    chk("x", int'(x[u]), ex);
    chk("err", int'(err[u]), ee);
    chk("y_ready_busy", int'(y_ready[u]), 0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("stall_x_valid", int'(x_valid[u]), 1);
      chk("stall_x", int'(x[u]), ex);
      chk("stall_err", int'(err[u]), ee);
      chk("stall_y_ready", int'(y_ready[u]), 0);
    end
    x_ready[u] = 1'b1;
    @(posedge clk); #1;
    x_ready[u] = 1'b0;
    chk("x_valid_drop", int'(x_valid[u]), 0);
    chk("y_ready_after", int'(y_ready[u]), 1);
  endtask

  task automatic do_reset(input int u);
    rst[u] = 1'b1;
    @(posedge clk); #1;
    rst[u] = 1'b0;
    for (int j = 0; j < 4; j++) mh[u][j] = 0;
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst[u]     = 1'b1;
      y[u]       = '0;
      y_valid[u] = 1'b0;
      x_ready[u] = 1'b0;
      for (int j = 0; j < 4; j++) mh[u][j] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    for (int u = 0; u < 2; u++) begin
      chk("rst_x", int'(x[u]), 0);
      chk("rst_err", int'(err[u]), 0);
      chk("rst_x_valid", int'(x_valid[u]), 0);
      chk("rst_y_ready", int'(y_ready[u]), 1);
    end

    // Nominal: x = 1, 2, -1, 3; last one held under backpressure.
    send(0, 1, 0);
    chk("nominal_hist", mh[0][1], 1);
    send(0, 4, 0);
    send(0, 6, 0);
    send(0, 11, 5);
    chk("nominal_last", mh[0][1], 3);

    // Saturation from reset.
    do_reset(0);
    send(0, 20, 0);
    send(0, 0, 0);

    // Inexact division with B = {2,1,1,1}.
    send(1, 3, 0);
    send(1, -5, 0);

    // Reset while the divider (or skip step) is in flight.
    y[0]       = 12'sd5;
    y_valid[0] = 1'b1;
    @(posedge clk); #1;
    y_valid[0] = 1'b0;
    repeat (SKIP0 ? 2 : 8) @(posedge clk);
    #1;
    do_reset(0);
    chk("midrst_x_valid", int'(x_valid[0]), 0);
    chk("midrst_y_ready", int'(y_ready[0]), 1);
    send(0, 1, 0);

    // Random streams on both instances.
    for (int i = 0; i < 12; i++) begin
      for (int u = 0; u < 2; u++) begin
        send(u, int'($urandom_range(0, 4000)) - 2000,
             int'($urandom_range(0, 2)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
